cbs_scheduler: RTL

Packet-level egress scheduler for the CBS path. The per-class routing stage fans traffic out by tdest into one queue per traffic class; this block re-merges those queues onto a single egress AXI4-Stream. Ordering is strict priority, and each queue's eligibility is gated by an 802.1Qav-style credit counter. Sits between the per-class queues and the MAC TX.

---
 rtl/cbs_pkg.sv | 22 ++
 rtl/cbs_credit_counter.sv | 60 ++++++
 rtl/cbs_scheduler.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cbs_pkg.sv
// Shared types and helpers for the credit-based-shaper egress scheduler.
package cbs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int unsigned tdest_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Signed credit saturation bounds for a counter of width w (w <= 63)
  function automatic longint credit_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint credit_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/cbs_credit_counter.sv
// One queue's 802.1Qav credit register with saturating update.
module cbs_credit_counter
  import cbs_pkg::*;
#(
  parameter int unsigned C_CREDIT_WIDTH = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             granted,
  input  logic                             beat,
  input  logic                             waiting,
  input  logic        [C_CREDIT_WIDTH-2:0] idle_slope,
  input  logic        [C_CREDIT_WIDTH-2:0] send_slope,
  output logic signed [C_CREDIT_WIDTH-1:0] credit
);

  localparam int unsigned CW = C_CREDIT_WIDTH;
  localparam int unsigned XW = CW + 1;
  localparam logic signed [XW-1:0] CR_MAX = XW'(credit_max(CW));
  localparam logic signed [XW-1:0] CR_MIN = XW'(credit_min(CW));

  logic signed [XW-1:0] cur;
  logic signed [XW-1:0] up;
  logic signed [XW-1:0] dn;
  logic signed [CW-1:0] nxt;

  function automatic logic signed [CW-1:0] sat(input logic signed [XW-1:0] v);
    if (v > CR_MAX) return CR_MAX[CW-1:0];
    if (v < CR_MIN) return CR_MIN[CW-1:0];
    return v[CW-1:0];
  endfunction

  // Arithmetic one bit wider than the register so overflow is detectable
  always_comb begin
    cur = {credit[CW-1], credit};
    up  = cur + $signed({2'b00, idle_slope});
    dn  = cur - $signed({2'b00, send_slope});
    nxt = credit;
    if (!en) begin
      nxt = '0;
    end else if (granted) begin
      if (beat) nxt = sat(dn);
    end else if (waiting) begin
      nxt = sat(up);
    end else if (!credit[CW-1]) begin
      nxt = '0;
    end else if (!up[XW-1] && (up != '0)) begin
      nxt = '0;
    end else begin
      nxt = up[CW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit <= '0;
    else     credit <= nxt;
  end

endmodule

// File: rtl/cbs_scheduler.sv
// Strict-priority, credit-gated packet scheduler merging per-class AXIS queues.
// Optional per-queue packet counters: define CBS_SCHEDULER_STATS_EN.
module cbs_scheduler
  import cbs_pkg::*;
#(
  parameter  int unsigned C_AXIS_TDATA_WIDTH = 8,
  parameter  int unsigned C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter  int unsigned C_NUM_QUEUES       = 4,
  parameter  int unsigned C_CREDIT_WIDTH     = 24,
  localparam int unsigned C_TDEST_WIDTH      = tdest_width(C_NUM_QUEUES)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [C_NUM_QUEUES*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_QUEUES*C_AXIS_TKEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [C_NUM_QUEUES-1:0]                      s_axis_tvalid,
  output logic [C_NUM_QUEUES-1:0]                      s_axis_tready,
  input  logic [C_NUM_QUEUES-1:0]                      s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0]                m_axis_tkeep,
  output logic                                         m_axis_tvalid,
  input  logic                                         m_axis_tready,
  output logic                                         m_axis_tlast,
  output logic [C_TDEST_WIDTH-1:0]                     m_axis_tdest,
`ifdef CBS_SCHEDULER_STATS_EN
  output logic [C_NUM_QUEUES*32-1:0]                   stat_pkt_cnt,
`endif
  input  logic [C_NUM_QUEUES-1:0]                      cbs_en,
  input  logic [C_NUM_QUEUES*(C_CREDIT_WIDTH-1)-1:0]   idle_slope,
  input  logic [C_NUM_QUEUES*(C_CREDIT_WIDTH-1)-1:0]   send_slope
);

  localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
  localparam int unsigned KW = C_AXIS_TKEEP_WIDTH;
  localparam int unsigned NQ = C_NUM_QUEUES;
  localparam int unsigned CW = C_CREDIT_WIDTH;
  localparam int unsigned SW = C_CREDIT_WIDTH - 1;
  localparam int unsigned TW = C_TDEST_WIDTH;

  state_t               state;
  logic [TW-1:0]        grant;
  logic [TW-1:0]        sel;
  logic                 any_elig;
  logic [NQ-1:0]        elig;
  logic                 beat;
  logic signed [CW-1:0] credit [NQ];

  // Highest-index eligible queue wins
  always_comb begin
    elig     = '0;
    sel      = '0;
    any_elig = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      elig[q] = s_axis_tvalid[q] && (!cbs_en[q] || !credit[q][CW-1]);
      if (elig[q]) begin
        sel      = TW'(q);
        any_elig = 1'b1;
      end
    end
  end

  // Egress mux: only the granted queue sees ready, and only while BUSY
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    for (int q = 0; q < NQ; q++) begin
      if (state == BUSY && grant == TW'(q)) begin
        m_axis_tdata     = s_axis_tdata[q*DW +: DW];
        m_axis_tkeep     = s_axis_tkeep[q*KW +: KW];
        m_axis_tvalid    = s_axis_tvalid[q];
        m_axis_tlast     = s_axis_tlast[q];
        s_axis_tready[q] = m_axis_tready;
      end
    end
  end

  assign beat         = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdest = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      case (state)
        IDLE: if (any_elig) begin
          grant <= sel;
          state <= BUSY;
        end
        BUSY: if (beat && m_axis_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar q = 0; q < NQ; q++) begin : g_q
    cbs_credit_counter #(
      .C_CREDIT_WIDTH(CW)
    ) u_cc (
      .clk       (clk),
      .rst       (rst),
      .en        (cbs_en[q]),
      .granted   (state == BUSY && grant == TW'(q)),
      .beat      (beat),
      .waiting   (s_axis_tvalid[q]),
      .idle_slope(idle_slope[q*SW +: SW]),
      .send_slope(send_slope[q*SW +: SW]),
      .credit    (credit[q])
    );
  end

`ifdef CBS_SCHEDULER_STATS_EN
  for (genvar q = 0; q < NQ; q++) begin : g_stat
    always_ff @(posedge clk or posedge rst) begin
      if (rst) stat_pkt_cnt[q*32 +: 32] <= '0;
      else if (beat && m_axis_tlast && grant == TW'(q))
        stat_pkt_cnt[q*32 +: 32] <= stat_pkt_cnt[q*32 +: 32] + 32'd1;
    end
  end
`endif

endmodule
